// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the dual-port SRAM bank
package sram_pkg;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    // Widest word byte_merge handles; callers size-cast in and out.
    localparam int MAX_DW = 1024;
    localparam int MAX_BW = MAX_DW / 8;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old,
        input logic [MAX_DW-1:0] wdata,
        input logic [MAX_BW-1:0] bmask
    );
        logic [MAX_DW-1:0] r;
        r = old;
        for (int k = 0; k < MAX_BW; k++) begin
            if (bmask[k]) r[k*8 +: 8] = wdata[k*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_dp_bank_rd_pipe.sv
// rtl/sram_dp_bank_rd_pipe.sv - per-port read pipeline, LAT stages of data + valid
module sram_rd_pipe #(
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [LAT-1:0] v;
    logic [DW-1:0]  d [LAT];

    // Data stages only load behind a valid so rdata holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign rvalid = v[LAT-1];
    assign rdata  = d[LAT-1];

endmodule

// File: rtl/sram_dp_bank.sv
// rtl/sram_dp_bank.sv - true dual-port byte-masked SRAM bank with clear sweep; SRAM_BYPASS_EN enables write-through on collisions
module sram_dp_bank
    import sram_pkg::*;
#(
    parameter  int DW     = 32,
    parameter  int DEPTH  = 2048,
    parameter  int RD_LAT = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = DW / 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req_a,
    input  logic          i_wren_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_wdata_a,
    input  logic [BW-1:0] i_bmask_a,
    output logic [DW-1:0] o_rdata_a,
    output logic          o_rvalid_a,
    input  logic          i_req_b,
    input  logic          i_wren_b,
    input  logic [AW-1:0] i_addr_b,
    input  logic [DW-1:0] i_wdata_b,
    input  logic [BW-1:0] i_bmask_b,
    output logic [DW-1:0] o_rdata_b,
    output logic          o_rvalid_b,
    output logic          o_ready
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("sram_dp_bank: RD_LAT must be 1 or 2");
    end

    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0] old,
        input logic [DW-1:0] wdata,
        input logic [BW-1:0] bmask
    );
        return DW'(byte_merge(MAX_DW'(old), MAX_DW'(wdata), MAX_BW'(bmask)));
    endfunction

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [DEPTH];

    logic          run, in_a, in_b, same;
    logic          wr_a, wr_b, wr_b_eff, rd_a, rd_b;
    logic [DW-1:0] word_a, word_b, wdat_a, wdat_b, rdw_a, rdw_b;

    assign run    = (state == S_READY);
    assign in_a   = 32'(i_addr_a) < DEPTH;
    assign in_b   = 32'(i_addr_b) < DEPTH;
    assign same   = (i_addr_a == i_addr_b);
    assign wr_a   = run & i_req_a & i_wren_a & in_a;
    assign wr_b   = run & i_req_b & i_wren_b & in_b;
    assign rd_a   = run & i_req_a & ~i_wren_a;
    assign rd_b   = run & i_req_b & ~i_wren_b;
    assign word_a = in_a ? mem[i_addr_a] : '0;
    assign word_b = in_b ? mem[i_addr_b] : '0;

    // A double write to one word is folded into port A's write: B's bytes
    // first, then A's on top, so A wins only where both masks overlap.
    assign wr_b_eff = wr_b & ~(wr_a & same);
    assign wdat_a   = merge(merge(word_a, i_wdata_b, (wr_b & same) ? i_bmask_b : '0),
                            i_wdata_a, i_bmask_a);
    assign wdat_b   = merge(word_b, i_wdata_b, i_bmask_b);

`ifdef SRAM_BYPASS_EN
    assign rdw_a = (wr_b & same) ? merge(word_a, i_wdata_b, i_bmask_b) : word_a;
    assign rdw_b = (wr_a & same) ? merge(word_b, i_wdata_a, i_bmask_a) : word_b;
`else
    assign rdw_a = word_a;
    assign rdw_b = word_b;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1)) state <= S_READY;
        end
    end

    // Array has no reset so it stays mappable onto block RAM; the sweep clears it.
    always_ff @(posedge i_clk) begin
        if (!run) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_a)     mem[i_addr_a] <= wdat_a;
            if (wr_b_eff) mem[i_addr_b] <= wdat_b;
        end
    end

    sram_rd_pipe #(.DW(DW), .LAT(RD_LAT)) u_pipe_a (
        .clk      (i_clk),
        .rst      (i_reset),
        .in_valid (rd_a),
        .in_data  (rdw_a),
        .rdata    (o_rdata_a),
        .rvalid   (o_rvalid_a)
    );

    sram_rd_pipe #(.DW(DW), .LAT(RD_LAT)) u_pipe_b (
        .clk      (i_clk),
        .rst      (i_reset),
        .in_valid (rd_b),
        .in_data  (rdw_b),
        .rdata    (o_rdata_b),
        .rvalid   (o_rvalid_b)
    );

    assign o_ready = run;

endmodule

// File: doc/sram_dp_bank.md
Name: sram_dp_bank

Overview:
Parametrised true dual-port word-addressed SRAM bank with per-byte write masks, a configurable read latency and per-port read-valid strobes.
- Clears its contents after reset with a sequential sweep FSM, not a single-cycle array reset, so it maps onto synthesizable block RAM.
- Defines cross-port collisions explicitly.
- Serves as the shared instruction/data memory behind the LSU and fetch ports.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
DEPTH, 2048, number of words; need not be a power of two
AW, $clog2(DEPTH), word-address width (derived localparam, not overridable)
BW, DW/8, byte-mask width (derived localparam)
RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  asynchronous active-high reset
i_req_a  input  1  port A request strobe
i_wren_a  input  1  port A write (1) / read (0); meaningful only with i_req_a
i_addr_a  input  AW  port A word address
i_wdata_a  input  DW  port A write data
i_bmask_a  input  BW  port A byte enables
o_rdata_a  output  DW  port A read data
o_rvalid_a  output  1  port A read data valid, one-cycle pulse
i_req_b, i_wren_b, i_addr_b, i_wdata_b, i_bmask_b  input  as port A  port B request fields
o_rdata_b  output  DW  port B read data
o_rvalid_b  output  1  port B read data valid
o_ready  output  1  bank initialised and accepting requests

Behaviour:
- Reset (async, active-high):
  - o_rdata_a/b = 0, o_rvalid_a/b = 0, o_ready = 0.
  - Read pipelines are flushed.
  - FSM enters S_CLEAR with clr_cnt = 0.
- Clear FSM:
  - S_CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. When clr_cnt == DEPTH-1, transition to S_READY on the next edge.
  - S_READY: terminal state; o_ready = 1. It is reached exactly DEPTH cycles after reset deassertion.
  - Reset asserted in either state returns the FSM to S_CLEAR with clr_cnt = 0. A sweep in progress restarts from 0.
- Request handling (S_READY only):
  - Requests while o_ready = 0 are ignored: no memory update and no rvalid.
  - Write (i_req & i_wren): byte k of mem[addr] is updated when bmask[k] = 1. A write produces no rvalid.
  - A write with bmask = 0 is a no-op.
  - Read (i_req & ~i_wren): rdata/rvalid appear RD_LAT cycles after the request edge.
  - RD_LAT = 1: rdata is registered from the array.
  - RD_LAT = 2: adds one output register stage.
  - rdata holds its last value when rvalid = 0.
  - Both ports are independent and fully pipelined: one request per port per cycle.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read returns rdata = 0 with rvalid = 1.
- Collisions (same address, same cycle):
  - Both write: per byte, port A wins where both masks are set. Bytes enabled by only one port take that port's data.
  - One reads, other writes: the read returns the old (pre-write) word (read-first), unless SRAM_BYPASS_EN is defined.
  - Both read: both return the same word.

Optional Feature:
SRAM_BYPASS_EN
- Defined: on a cross-port read/write collision, the read returns the merged word. Written bytes come from the writer's wdata; unmasked bytes come from the old contents (write-through). Latency is unchanged.
- Undefined: read-first as above, with no bypass mux in the read path.

Decomposition:
- Package sram_pkg holds:
  - FSM state enum (S_CLEAR, S_READY).
  - Function byte_merge(old, wdata, bmask), used by the write path and the bypass path.
  - Legal-RD_LAT check constant.
- Sub-module sram_rd_pipe: a per-port read pipeline (RD_LAT stages of data + valid, async reset to 0), instantiated twice.

Test Plan:
- Reset, then hold idle: o_ready rises exactly DEPTH cycles after reset release (2048 at default). Reads of addresses 0, 1023 and 2047 all return 0x00000000.
- Write A addr 5 data 0xDEADBEEF bmask 4'b1111, then write A addr 5 data 0x00001234 bmask 4'b0011. Read B addr 5 returns 0xDEAD1234 with rvalid exactly RD_LAT cycles after the request. Run with RD_LAT = 1 and RD_LAT = 2.
- Same cycle: A writes addr 9 = 0x11111111 bmask 4'b0011, and B writes addr 9 = 0x22222222 bmask 4'b0110. A later read returns 0x00221111.
- Addr 7 holds 0xAAAAAAAA; same cycle, A writes 0x55555555 bmask 4'b1111 and B reads addr 7. B returns 0xAAAAAAAA without SRAM_BYPASS_EN, and 0x55555555 with it defined.
- Request issued during S_CLEAR (write addr 3 = 0xFF) is ignored: no rvalid, and addr 3 reads 0 after o_ready.
- Reset asserted mid-sweep and mid-read: rvalid drops immediately and does not pulse. o_ready returns to 0 and then rises DEPTH cycles after release. A read issued on the release edge produces no rvalid. With DEPTH = 2000, a read of addr 2047 returns 0 with rvalid = 1.
